// File: rtl/secret_store_reader_pkg.sv
// ---------------------------------------------------------------------------
// secret_store_pkg
// Shared definitions for the secret store reader:
//   state_e    : store FSM states (ST_VERIFY only reachable when
//                SECRET_SCRUB_VERIFY_EN is defined)
//   SCRUB_ZERO : value written into every entry while scrubbing
//   idx_w()    : entry index width for a given DEPTH (at least 1 bit)
// ---------------------------------------------------------------------------
package secret_store_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD   = 3'd1,
      ST_ARMED  = 3'd2,
      ST_SCRUB  = 3'd3,
      ST_VERIFY = 3'd4
   } state_e;

   // Wide enough for any practical word width; users slice [DATA_W-1:0].
   localparam logic [255:0] SCRUB_ZERO = '0;

   function automatic int idx_w(input int depth);
      return (depth <= 2) ? 1 : $clog2(depth);
   endfunction

endpackage

// File: rtl/secret_store_reader_if.sv
// ---------------------------------------------------------------------------
// secret_store_reader_if
// Write (loader) and read (crypto engine) handshake bundle of the store.
//   wr_valid/wr_ready/wr_data/wr_last : loader -> store word transfer
//   rd_req/rd_addr                    : engine read request
//   rd_valid/rd_data                  : 1-cycle read response
// master: loader/engine side.  slave: the store.
// ---------------------------------------------------------------------------
interface secret_store_reader_if
   import secret_store_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 4
);
   localparam int IDX_W = idx_w(DEPTH);

   logic              wr_valid;
   logic              wr_ready;
   logic [DATA_W-1:0] wr_data;
   logic              wr_last;
   logic              rd_req;
   logic [IDX_W-1:0]  rd_addr;
   logic              rd_valid;
   logic [DATA_W-1:0] rd_data;

   modport master (
      output wr_valid, wr_data, wr_last, rd_req, rd_addr,
      input  wr_ready, rd_valid, rd_data
   );

   modport slave (
      input  wr_valid, wr_data, wr_last, rd_req, rd_addr,
      output wr_ready, rd_valid, rd_data
   );
endinterface

// File: rtl/secret_store_reader_scrub_seq.sv
// ---------------------------------------------------------------------------
// secret_scrub_seq
// Entry index walker shared by the SCRUB and VERIFY passes.
//   clk, rst_n : clock, asynchronous active-low reset
//   run        : walk while high; index returns to 0 when low
//   idx        : current entry index
//   last       : idx is the final entry (DEPTH-1)
//   done       : run && last (pass completes on this edge)
// The index wraps to 0 after the last entry, so a VERIFY pass that directly
// follows SCRUB starts from entry 0 without an idle cycle.
// ---------------------------------------------------------------------------
module secret_scrub_seq
   import secret_store_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int IDX_W = idx_w(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             run,
   output logic [IDX_W-1:0] idx,
   output logic             last,
   output logic             done
);

   logic [IDX_W-1:0] idx_q, idx_d;

   always_comb begin
      idx_d = '0;
      if (run && !last) idx_d = idx_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) idx_q <= '0;
      else        idx_q <= idx_d;
   end

   assign idx  = idx_q;
   assign last = (idx_q == IDX_W'(DEPTH - 1));
   assign done = run && last;

endmodule

// File: rtl/secret_store_reader.sv
// ---------------------------------------------------------------------------
// secret_store_reader
// Holding store for a secret of up to DEPTH words. Words arrive over the
// bus write handshake, are served over a 1-cycle read port while ARMED, and
// every entry is zeroed (SCRUB) before a new secret may be loaded.
//   clk, rst_n  : clock, asynchronous active-low reset (zeroes all entries)
//   bus (slave) : write/read handshake, see secret_store_reader_if
//   release_req : engine finished with the secret; starts scrub
//                 ("release" itself is a reserved word in SystemVerilog)
//   armed       : secret complete and readable
//   load_err    : sticky overflow flag, cleared by next accepted first word
//   scrub_done  : one-cycle pulse when the scrub pass completes
//   scrub_err   : sticky verify failure
// Optional feature macro: SECRET_SCRUB_VERIFY_EN adds a VERIFY pass that
// reads back every entry after SCRUB; without it scrub_err is tied to 0.
// ---------------------------------------------------------------------------
module secret_store_reader
   import secret_store_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   secret_store_reader_if.slave         bus,
   input  logic                         release_req,
   output logic                         armed,
   output logic                         load_err,
   output logic                         scrub_done,
   output logic                         scrub_err
);

   localparam int IDX_W = idx_w(DEPTH);
   localparam int CNT_W = IDX_W + 1;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] mem_d [DEPTH];
   logic              wr_ready_q, wr_ready_d;
   logic              rd_valid_q, rd_valid_d;
   logic [DATA_W-1:0] rd_data_q, rd_data_d;
   logic              load_err_q, load_err_d;
   logic              scrub_done_q, scrub_done_d;
`ifdef SECRET_SCRUB_VERIFY_EN
   logic              scrub_err_q, scrub_err_d;
`endif

   logic              wr_fire;
   logic              seq_run, seq_last, seq_done;
   logic [IDX_W-1:0]  seq_idx;

   assign wr_fire = bus.wr_valid && wr_ready_q;
   assign seq_run = (state_q == ST_SCRUB) || (state_q == ST_VERIFY);

   secret_scrub_seq #(.DEPTH(DEPTH)) u_scrub_seq (
      .clk   (clk),
      .rst_n (rst_n),
      .run   (seq_run),
      .idx   (seq_idx),
      .last  (seq_last),
      .done  (seq_done)
   );

   always_comb begin
      state_d      = state_q;
      count_d      = count_q;
      mem_d        = mem_q;
      rd_valid_d   = 1'b0;
      rd_data_d    = '0;
      load_err_d   = load_err_q;
      scrub_done_d = 1'b0;
`ifdef SECRET_SCRUB_VERIFY_EN
      scrub_err_d  = scrub_err_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (wr_fire) begin
               mem_d[0]   = bus.wr_data;
               count_d    = CNT_W'(1);
               load_err_d = 1'b0;
               state_d    = bus.wr_last ? ST_ARMED : ST_LOAD;
            end
         end
         ST_LOAD: begin
            // A release racing a word still discards the word and scrubs.
            if (release_req) begin
               count_d = '0;
               state_d = ST_SCRUB;
            end else if (wr_fire) begin
               if (count_q == CNT_W'(DEPTH)) begin
                  load_err_d = 1'b1;
                  count_d    = '0;
                  state_d    = ST_SCRUB;
               end else begin
                  mem_d[count_q[IDX_W-1:0]] = bus.wr_data;
                  count_d = count_q + 1'b1;
                  if (bus.wr_last) state_d = ST_ARMED;
               end
            end
         end
         ST_ARMED: begin
            if (release_req) begin
               count_d = '0;
               state_d = ST_SCRUB;
            end else if (bus.rd_req) begin
               rd_valid_d = 1'b1;
               // Entries beyond the loaded secret read as zero.
               if ({1'b0, bus.rd_addr} < count_q) rd_data_d = mem_q[bus.rd_addr];
            end
         end
         ST_SCRUB: begin
            mem_d[seq_idx] = SCRUB_ZERO[DATA_W-1:0];
            if (seq_done) begin
`ifdef SECRET_SCRUB_VERIFY_EN
               state_d      = ST_VERIFY;
`else
               state_d      = ST_IDLE;
               scrub_done_d = 1'b1;
`endif
            end
         end
         ST_VERIFY: begin
`ifdef SECRET_SCRUB_VERIFY_EN
            if (|mem_q[seq_idx]) scrub_err_d = 1'b1;
            if (seq_done) begin
               state_d      = ST_IDLE;
               scrub_done_d = 1'b1;
            end
`else
            state_d = ST_IDLE;
`endif
         end
         default: state_d = ST_IDLE;
      endcase
      // Registered so wr_ready stays low until the first edge after reset.
      wr_ready_d = (state_d == ST_IDLE) || (state_d == ST_LOAD);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         count_q      <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ready_q   <= 1'b0;
         rd_valid_q   <= 1'b0;
         rd_data_q    <= '0;
         load_err_q   <= 1'b0;
         scrub_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         count_q      <= count_d;
         mem_q        <= mem_d;
         wr_ready_q   <= wr_ready_d;
         rd_valid_q   <= rd_valid_d;
         rd_data_q    <= rd_data_d;
         load_err_q   <= load_err_d;
         scrub_done_q <= scrub_done_d;
      end
   end

`ifdef SECRET_SCRUB_VERIFY_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) scrub_err_q <= 1'b0;
      else        scrub_err_q <= scrub_err_d;
   end
   assign scrub_err = scrub_err_q;
`else
   assign scrub_err = 1'b0;
`endif

   assign bus.wr_ready = wr_ready_q;
   assign bus.rd_valid = rd_valid_q;
   assign bus.rd_data  = rd_data_q;
   assign armed        = (state_q == ST_ARMED);
   assign load_err     = load_err_q;
   assign scrub_done   = scrub_done_q;

endmodule

// File: doc/secret_store_reader.md
# secret_store_reader

Consumer-side holding store for secret words produced by the secret loader path. Accepts a burst of up to DEPTH secret words over a valid/ready write handshake, serves them to the downstream crypto engine through a 1-cycle read port, and zeroizes every entry before it accepts a new secret. Storage and outputs never hold X or stale secret data: reset, release and abort all end in known-zero contents.

## Interface
- DATA_W, 32: secret word width
- DEPTH, 4: number of secret words held (power of two, ≥2)
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- wr_valid  in  1  loader offers a secret word
- wr_ready  out  1  store accepts a word (IDLE/LOAD only)
- wr_data  in  DATA_W  secret word
- wr_last  in  1  marks the final word of the secret
- rd_req  in  1  engine read request (ARMED only)
- rd_addr  in  $clog2(DEPTH)  entry index
- rd_valid  out  1  read response valid
- rd_data  out  DATA_W  read response; zero whenever rd_valid=0
- release  in  1  engine done with secret; starts scrub
- armed  out  1  secret complete and readable
- load_err  out  1  sticky: more than DEPTH words offered; cleared on next accepted first word
- scrub_done  out  1  one-cycle pulse when scrub completes
- scrub_err  out  1  sticky scrub verify failure (see Configuration)

## Operation
- States: IDLE, LOAD, ARMED, SCRUB (plus VERIFY when configured).
- IDLE: wr_ready=1; accepted word written to entry 0, count=1; wr_last → ARMED, else → LOAD.
- LOAD: wr_ready=1; each accepted word written to entry count, count+1; wr_last → ARMED. Word accepted while count==DEPTH → load_err=1, word discarded, → SCRUB.
- ARMED: wr_ready=0, armed=1. rd_req with rd_addr<count → rd_data=entry next cycle; rd_addr≥count → rd_valid=1, rd_data=0.
- release in LOAD or ARMED → SCRUB; release in IDLE/SCRUB ignored.
- release and rd_req same cycle: release wins, no rd_valid.
- SCRUB: scrub_idx walks 0..DEPTH-1, writes zero to one entry per cycle; count cleared on entry. After entry DEPTH-1 → IDLE (or VERIFY) with scrub_done pulse on the IDLE transition.
- wr_ready=0, rd_valid=0 throughout SCRUB.

## Timing
- Reset (async assert): all entries, count, scrub_idx=0; state IDLE; all outputs 0 (wr_ready rises first clk after deassert).
- Write: accepted on edge where wr_valid&wr_ready; armed=1 the cycle after wr_last accepted.
- Read latency: 1 cycle; rd_valid is a single-cycle pulse per request; back-to-back requests give back-to-back responses.
- Scrub: exactly DEPTH cycles from release edge to scrub_done (DEPTH more with VERIFY).
- Reset mid-LOAD/ARMED/SCRUB: contents zeroed immediately, no scrub_done pulse.

## Configuration
- SECRET_SCRUB_VERIFY_EN defined: VERIFY state after SCRUB reads each entry over DEPTH cycles, OR-reduces; any nonzero bit sets scrub_err (sticky until reset); scrub_done pulses on VERIFY→IDLE.
- Undefined: SCRUB→IDLE directly; scrub_err tied 0.

## Structure
- Package secret_store_pkg: state enum, SCRUB_ZERO constant, helper for index width.
- Sub-module secret_scrub_seq: scrub_idx counter, done/last-index flags, shared by SCRUB and VERIFY.

## Test plan
- Load 0xDEAD0001..0xDEAD0004, last on 4th; read addr 2 → rd_data=0xDEAD0003 one cycle later, armed=1.
- Load 2 words (last on 2nd), read addr 3 → rd_valid=1, rd_data=0.
- Offer 5 words with no wr_last → load_err=1, SCRUB entered, scrub_done after 4 cycles; reads of old values impossible.
- release in ARMED, then reload 0x1 single word; read addr 1..3 → all 0 (no previous-secret leakage).
- rst_n low mid-ARMED for one cycle → armed=0, all entries zero, no scrub_done; subsequent read after new load of 0x5 at addr 1 → 0.
- With SECRET_SCRUB_VERIFY_EN: release → scrub_done after 8 cycles, scrub_err=0; force entry nonzero during VERIFY → scrub_err=1 sticky.
